// File: rtl/ts_udp_packer.sv
// ts_udp_packer: locks onto a 188-byte MPEG-TS stream, collects PKTS packets per bank of a
// ping-pong RAM and emits each filled bank as one UDP payload frame behind an 8-byte prefix.
module ts_udp_packer #(
  parameter int PKTS        = 7,
  parameter int TIMEOUT_CYC = 125000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dst_ip,
  input  logic [15:0] dst_port,
  input  logic [7:0]  ts_din,
  input  logic        ts_din_en,
  input  logic        udp_prog_full,
  output logic [7:0]  udp_dout,
  output logic        udp_dout_en,
  output logic        frame_start,
  output logic        sync_err,
  output logic        overflow,
  output logic [2:0]  dbg_state
);
  localparam int PB    = 188;
  localparam int BANK  = PKTS * PB;
  localparam int DEPTH = 2 * BANK;
  localparam int AW    = $clog2(DEPTH);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam int WPW   = $clog2(PKTS + 1);

  typedef enum logic {HUNT, LOCK} al_t;
  typedef enum logic [1:0] {IDLE, HDR, PAY, DONE} rd_t;

  al_t              al_state;
  logic [7:0]       bcnt;
  logic [WPW-1:0]   wr_pkt;
  logic             wr_bank;
  logic             drop;
  logic [AW-1:0]    pkt_base;
  logic [1:0]       full;
  logic [15:0]      bank_len [2];
  logic [TW-1:0]    tcnt;

  rd_t              rd_state;
  logic             rd_bank;
  logic [3:0]       hcnt;
  logic [15:0]      pcnt;
  logic [15:0]      len_q;
  logic [23:0]      ip_q;
  logic [15:0]      port_q;
  logic [7:0]       hdr_q;
  logic             pay_sel;

  logic [7:0]       mem [DEPTH];
  logic [7:0]       ram_q;

  logic             bad_sync, accept, drop_now, wr_en, pkt_last, timeout_hit, rd_re;
  logic [AW-1:0]    wr_addr, rd_addr;

  always_comb begin
    bad_sync    = (al_state == LOCK) && (bcnt == 8'd0) && (ts_din != 8'h47);
    accept      = ts_din_en && (al_state == LOCK ? !bad_sync : ts_din == 8'h47);
    // A packet's fate is decided at its first byte and held for the rest of it.
    drop_now    = (bcnt == 8'd0) ? full[wr_bank] : drop;
    wr_en       = accept && !drop_now;
    pkt_last    = accept && (al_state == LOCK) && (bcnt == 8'd187);
    timeout_hit = !ts_din_en && (tcnt == TW'(TIMEOUT_CYC - 1));
    wr_addr     = (wr_bank ? AW'(BANK) : AW'(0)) + pkt_base + AW'(bcnt);
    rd_re       = ((rd_state == HDR) && (hcnt == 4'd8)) || ((rd_state == PAY) && (pcnt != len_q));
    rd_addr     = (rd_bank ? AW'(BANK) : AW'(0)) + ((rd_state == PAY) ? pcnt[AW-1:0] : AW'(0));
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= ts_din;
    if (rd_re) ram_q <= mem[rd_addr];
  end

  // Aligner / bank writer. Owns the full flags; the reader releases its bank while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_state    <= HUNT;
      bcnt        <= '0;
      wr_pkt      <= '0;
      wr_bank     <= 1'b0;
      drop        <= 1'b0;
      pkt_base    <= '0;
      full        <= '0;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      tcnt        <= '0;
      sync_err    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      overflow <= 1'b0;
      if (rd_state == DONE) full[rd_bank] <= 1'b0;
      if (ts_din_en) tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT_CYC)) tcnt <= tcnt + 1'b1;
      if (ts_din_en) begin
        if (bad_sync) begin
          sync_err <= 1'b1;
          al_state <= HUNT;
        end else if (accept) begin
          al_state <= LOCK;
          if (bcnt == 8'd0) drop <= full[wr_bank];
          if (pkt_last) begin
            bcnt <= '0;
            if (drop) begin
              overflow <= 1'b1;
            end else if (wr_pkt == WPW'(PKTS - 1)) begin
              full[wr_bank]     <= 1'b1;
              bank_len[wr_bank] <= 16'(BANK);
              wr_bank           <= ~wr_bank;
              wr_pkt            <= '0;
              pkt_base          <= '0;
            end else begin
              wr_pkt   <= wr_pkt + 1'b1;
              pkt_base <= pkt_base + AW'(PB);
            end
          end else begin
            bcnt <= bcnt + 8'd1;
          end
        end
      end else if (timeout_hit) begin
        al_state <= HUNT;
        bcnt     <= '0;
        if (wr_pkt != '0) begin
          full[wr_bank]     <= 1'b1;
          bank_len[wr_bank] <= 16'(wr_pkt) * 16'(PB);
          wr_bank           <= ~wr_bank;
          wr_pkt            <= '0;
          pkt_base          <= '0;
        end
      end
    end
  end

  // Frame reader. udp_dout_en is a valid with no per-byte ready: once a frame starts it runs
  // to the end; udp_prog_full only gates the decision to start a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state    <= IDLE;
      rd_bank     <= 1'b0;
      hcnt        <= '0;
      pcnt        <= '0;
      len_q       <= '0;
      ip_q        <= '0;
      port_q      <= '0;
      hdr_q       <= '0;
      pay_sel     <= 1'b0;
      udp_dout_en <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      case (rd_state)
        IDLE: if (full[rd_bank] && !udp_prog_full) begin
          rd_state    <= HDR;
          ip_q        <= dst_ip[23:0];
          port_q      <= dst_port;
          len_q       <= bank_len[rd_bank];
          hdr_q       <= dst_ip[31:24];
          udp_dout_en <= 1'b1;
          frame_start <= 1'b1;
          hcnt        <= 4'd1;
        end
        HDR: begin
          frame_start <= 1'b0;
          hcnt        <= hcnt + 4'd1;
          case (hcnt)
            4'd1: hdr_q <= ip_q[23:16];
            4'd2: hdr_q <= ip_q[15:8];
            4'd3: hdr_q <= ip_q[7:0];
            4'd4: hdr_q <= port_q[15:8];
            4'd5: hdr_q <= port_q[7:0];
            4'd6: hdr_q <= len_q[15:8];
            4'd7: hdr_q <= len_q[7:0];
            default: begin
              rd_state <= PAY;
              hdr_q    <= '0;
              pay_sel  <= 1'b1;
              pcnt     <= 16'd1;
            end
          endcase
        end
        PAY: if (pcnt == len_q) begin
          rd_state    <= DONE;
          udp_dout_en <= 1'b0;
          pay_sel     <= 1'b0;
        end else begin
          pcnt <= pcnt + 16'd1;
        end
        default: begin
          rd_bank  <= ~rd_bank;
          rd_state <= IDLE;
        end
      endcase
    end
  end

  assign udp_dout  = pay_sel ? ram_q : hdr_q;
  assign dbg_state = {al_state == LOCK, rd_state};
endmodule
